// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx between NUM_REQ byte producers.
// Arbitration is round-robin and each grant sends one byte. The arbiter drives
// start/data into uart_tx and waits for its done pulse before the next grant.
// Optional feature: define UART_ARB_TAG_EN to send a tag byte {4'hA, id}
// ahead of every granted data byte.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | no transfer in flight; picks the next valid requester
// S_LAUNCH   | start (and ack, for the first byte) pulse is on the outputs
// S_WAIT     | last byte of the grant is shifting out; waits for done
// S_TAG_WAIT | tag byte is shifting out; the data byte follows on done
module uart_tx_arbiter #(
   parameter  int NUM_REQ = 4,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req_valid_i,
   input  logic [8*NUM_REQ-1:0] req_data_i,
   output logic [NUM_REQ-1:0]   req_ack_o,
   output logic                 tx_start_o,
   output logic [7:0]           tx_data_o,
   input  logic                 tx_active_i,
   input  logic                 tx_done_i,
   output logic                 busy_o,
   output logic [ID_W-1:0]      grant_id_o
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_LAUNCH   = 2'd1,
      S_WAIT     = 2'd2,
      S_TAG_WAIT = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [ID_W-1:0]      last_q, last_d;
   logic [NUM_REQ-1:0]   ack_q, ack_d;
   logic                 start_q, start_d;
   logic [7:0]           data_q, data_d;
   logic                 busy_q, busy_d;
   logic [ID_W-1:0]      gid_q, gid_d;
`ifdef UART_ARB_TAG_EN
   logic [7:0]           hold_q, hold_d;
   logic                 second_q, second_d;
`endif

   logic                 pick_found;
   logic [ID_W-1:0]      pick_idx;
   logic [ID_W-1:0]      cand;
   logic [7:0]           req_byte [NUM_REQ];

   // uart_tx activity is status only; nothing here depends on it
   logic                 unused_tx_active;
   assign unused_tx_active = tx_active_i;

   for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
      assign req_byte[k] = req_data_i[8*k +: 8];
   end

   // Round-robin pick: lowest valid index above last, else lowest valid at or below last
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = ID_W'(i);
         if (!pick_found && req_valid_i[cand] && (cand > last_q)) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = ID_W'(i);
         if (!pick_found && req_valid_i[cand] && (cand <= last_q)) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   // State and registered outputs; reset aborts any byte in flight
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         last_q   <= ID_W'(NUM_REQ - 1);
         ack_q    <= '0;
         start_q  <= 1'b0;
         data_q   <= 8'h00;
         busy_q   <= 1'b0;
         gid_q    <= '0;
`ifdef UART_ARB_TAG_EN
         hold_q   <= 8'h00;
         second_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         ack_q    <= ack_d;
         start_q  <= start_d;
         data_q   <= data_d;
         busy_q   <= busy_d;
         gid_q    <= gid_d;
`ifdef UART_ARB_TAG_EN
         hold_q   <= hold_d;
         second_q <= second_d;
`endif
      end
   end

   // Next-state: done is only honoured while a byte is known to be in flight
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:     if (pick_found) state_d = S_LAUNCH;
`ifdef UART_ARB_TAG_EN
         S_LAUNCH:   state_d = second_q ? S_WAIT : S_TAG_WAIT;
         S_TAG_WAIT: if (tx_done_i) state_d = S_LAUNCH;
`else
         S_LAUNCH:   state_d = S_WAIT;
`endif
         S_WAIT:     if (tx_done_i) state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   // Output/datapath next values; ack and start are single-cycle pulses
   always_comb begin
      ack_d    = '0;
      start_d  = 1'b0;
      data_d   = data_q;
      busy_d   = busy_q;
      gid_d    = gid_q;
      last_d   = last_q;
`ifdef UART_ARB_TAG_EN
      hold_d   = hold_q;
      second_d = second_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (pick_found) begin
`ifdef UART_ARB_TAG_EN
               data_d   = {4'hA, 4'(pick_idx)};
               hold_d   = req_byte[pick_idx];
               second_d = 1'b0;
`else
               data_d   = req_byte[pick_idx];
`endif
               gid_d            = pick_idx;
               last_d           = pick_idx;
               busy_d           = 1'b1;
               ack_d[pick_idx]  = 1'b1;
               start_d          = 1'b1;
            end
         end
         S_WAIT: begin
            if (tx_done_i) busy_d = 1'b0;
         end
`ifdef UART_ARB_TAG_EN
         S_TAG_WAIT: begin
            if (tx_done_i) begin
               data_d   = hold_q;
               start_d  = 1'b1;
               second_d = 1'b1;
            end
         end
`endif
         default: ;
      endcase
   end

   assign req_ack_o  = ack_q;
   assign tx_start_o = start_q;
   assign tx_data_o  = data_q;
   assign busy_o     = busy_q;
   assign grant_id_o = gid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized requester
// queues checked against a queue-level round-robin model.
module tb_uart_tx_arbiter;
   localparam int NUM_REQ = 4;
`ifdef UART_ARB_TAG_EN
   localparam int TAG = 1;
`else
   localparam int TAG = 0;
`endif
   localparam int STEP = TAG + 1;

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic [NUM_REQ-1:0]   req_valid_i = '0;
   logic [8*NUM_REQ-1:0] req_data_i = '0;
   logic [NUM_REQ-1:0]   req_ack_o;
   logic                 tx_start_o;
   logic [7:0]           tx_data_o;
   logic                 tx_active_i = 1'b0;
   logic                 tx_done_i = 1'b0;
   logic                 busy_o;
   logic [1:0]           grant_id_o;

   uart_tx_arbiter #(.NUM_REQ(NUM_REQ)) dut (
      .clk(clk), .reset(reset),
      .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_ack_o(req_ack_o),
      .tx_start_o(tx_start_o), .tx_data_o(tx_data_o),
      .tx_active_i(tx_active_i), .tx_done_i(tx_done_i),
      .busy_o(busy_o), .grant_id_o(grant_id_o)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int uart_cnt = 0;
   bit auto_uart = 0;
   bit rand_mode = 0;
   int         obs_id[$];
   logic [7:0] obs_data[$];
   logic [3:0] obs_ack[$];
   logic [7:0] rq_mem [NUM_REQ][8];
   int         rq_len [NUM_REQ];
   int         rq_head[NUM_REQ];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_req(input int k);
      req_valid_i[k] = (rq_head[k] < rq_len[k]);
      req_data_i[8*k +: 8] = req_valid_i[k] ? rq_mem[k][rq_head[k]] : 8'h00;
   endtask

   // One clock: sample just after the edge, log starts, then play uart_tx and requesters
   task automatic tick();
      @(posedge clk);
      #1;
      if (tx_start_o) begin
         chk("start_while_active", 32'(tx_active_i), 32'd0);
         obs_id.push_back(int'(grant_id_o));
         obs_data.push_back(tx_data_o);
         obs_ack.push_back(req_ack_o);
      end
      tx_done_i = 1'b0;
      if (uart_cnt > 0) begin
         uart_cnt--;
         if (uart_cnt == 0) begin
            tx_done_i   = 1'b1;
            tx_active_i = 1'b0;
         end
      end
      if (auto_uart && tx_start_o) begin
         uart_cnt    = int'($urandom_range(5, 1));
         tx_active_i = 1'b1;
      end
      if (rand_mode) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            if (req_ack_o[k]) begin
               rq_head[k]++;
               drive_req(k);
            end
         end
      end
   endtask

   task automatic do_reset();
      reset       = 1'b1;
      req_valid_i = '0;
      req_data_i  = '0;
      tx_done_i   = 1'b0;
      tx_active_i = 1'b0;
      uart_cnt    = 0;
      auto_uart   = 0;
      rand_mode   = 0;
      tick();
      tick();
      obs_id.delete();
      obs_data.delete();
      obs_ack.delete();
      reset = 1'b0;
   endtask

   task automatic wait_starts(input int n, input int budget, input string tag);
      int b = 0;
      while (obs_id.size() < n && b < budget) begin
         tick();
         b++;
      end
      chk(tag, 32'(obs_id.size() >= n), 32'd1);
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int b = 0;
      while ((busy_o || uart_cnt != 0) && b < budget) begin
         tick();
         b++;
      end
      chk(tag, 32'(busy_o), 32'd0);
   endtask

   initial begin
      int         exp_id[$];
      logic [7:0] exp_byte[$];
      int         m_left[NUM_REQ];
      int         m_last, total, c;
      bit         found;

      // Reset values, observed while reset is held
      reset = 1'b1;
      tick();
      tick();
      chk("rst_ack",   32'(req_ack_o),  32'd0);
      chk("rst_start", 32'(tx_start_o), 32'd0);
      chk("rst_data",  32'(tx_data_o),  32'h00);
      chk("rst_busy",  32'(busy_o),     32'd0);
      chk("rst_gid",   32'(grant_id_o), 32'd0);

`ifndef UART_ARB_TAG_EN
      // Single requester 2, byte 5C, done driven by hand
      do_reset();
      req_valid_i[2] = 1'b1;
      req_data_i[23:16] = 8'h5C;
      tick();
      chk("single_ack",   32'(req_ack_o),  32'b0100);
      chk("single_start", 32'(tx_start_o), 32'd1);
      chk("single_data",  32'(tx_data_o),  32'h5C);
      chk("single_gid",   32'(grant_id_o), 32'd2);
      chk("single_busy",  32'(busy_o),     32'd1);
      req_valid_i[2] = 1'b0;
      tick();
      chk("single_start_pulse", 32'(tx_start_o), 32'd0);
      chk("single_ack_pulse",   32'(req_ack_o),  32'd0);
      tick();
      chk("single_busy_wait", 32'(busy_o), 32'd1);
      tx_done_i = 1'b1;
      tick();
      chk("single_busy_done", 32'(busy_o), 32'd0);

      // Back-to-back: start exactly two cycles after the done pulse
      do_reset();
      req_valid_i[1] = 1'b1;
      req_data_i[15:8] = 8'h21;
      tick();
      chk("b2b_first_ack", 32'(req_ack_o), 32'b0010);
      req_data_i[15:8] = 8'h22;
      tx_active_i = 1'b1;
      tick();
      tick();
      tick();
      tx_done_i   = 1'b1;
      tx_active_i = 1'b0;
      tick();
      chk("b2b_no_start_d1", 32'(tx_start_o), 32'd0);
      tick();
      chk("b2b_start_d2", 32'(tx_start_o), 32'd1);
      chk("b2b_data",     32'(tx_data_o),  32'h22);
      chk("b2b_ack",      32'(req_ack_o),  32'b0010);
      req_valid_i = '0;
      tick();
      tx_done_i = 1'b1;
      tick();
      chk("b2b_idle", 32'(busy_o), 32'd0);
`else
      // Tag mode: requester 3 with C4 sends A3 then C4 under one ack
      do_reset();
      auto_uart = 1;
      req_valid_i[3] = 1'b1;
      req_data_i[31:24] = 8'hC4;
      wait_starts(1, 50, "tag_first_start");
      req_valid_i = '0;
      wait_starts(2, 50, "tag_second_start");
      chk("tag_busy_second", 32'(busy_o), 32'd1);
      wait_idle(50, "tag_idle");
      chk("tag_nstarts", 32'(obs_id.size()), 32'd2);
      if (obs_id.size() >= 2) begin
         chk("tag_byte0", 32'(obs_data[0]), 32'hA3);
         chk("tag_ack0",  32'(obs_ack[0]),  32'b1000);
         chk("tag_byte1", 32'(obs_data[1]), 32'hC4);
         chk("tag_ack1",  32'(obs_ack[1]),  32'd0);
      end
`endif

      // Round robin with all four requesters permanently valid
      do_reset();
      auto_uart = 1;
      req_valid_i = 4'b1111;
      req_data_i  = 32'h13121110;
      wait_starts(5 * STEP, 400, "rr_starts");
      req_valid_i = '0;
      wait_idle(100, "rr_idle");
      for (int i = 0; i < 5; i++) begin
         if (i * STEP + TAG < obs_id.size()) begin
            chk($sformatf("rr_id%0d", i),   32'(obs_id[i*STEP]),       32'(i % 4));
            chk($sformatf("rr_ack%0d", i),  32'(obs_ack[i*STEP]),      32'd1 << (i % 4));
            chk($sformatf("rr_data%0d", i), 32'(obs_data[i*STEP+TAG]), 32'h10 + 32'(i % 4));
         end
      end

      // Spurious done while idle
      tx_done_i = 1'b1;
      tick();
      chk("spur_ack",   32'(req_ack_o),  32'd0);
      chk("spur_start", 32'(tx_start_o), 32'd0);
      chk("spur_busy",  32'(busy_o),     32'd0);
      tick();
      chk("spur_start2", 32'(tx_start_o), 32'd0);
      chk("spur_busy2",  32'(busy_o),     32'd0);

      // Reset mid-byte: after granting 1, requester 3 would be next; reset restores 0 first
      do_reset();
      req_valid_i[1] = 1'b1;
      req_data_i[15:8] = 8'h31;
      tick();
      chk("rmid_gid1", 32'(grant_id_o), 32'd1);
      req_valid_i = 4'b1001;
      req_data_i  = 32'h43000040;
      tick();
      tick();
      reset = 1'b1;
      #1;
      chk("rmid_busy",  32'(busy_o),     32'd0);
      chk("rmid_start", 32'(tx_start_o), 32'd0);
      chk("rmid_ack",   32'(req_ack_o),  32'd0);
      tick();
      reset = 1'b0;
      auto_uart = 1;
      tick();
      chk("rmid_regrant_gid", 32'(grant_id_o), 32'd0);
      chk("rmid_regrant_ack", 32'(req_ack_o),  32'b0001);
      chk("rmid_regrant_data", 32'(tx_data_o), TAG ? 32'hA0 : 32'h40);
      req_valid_i = '0;
      wait_idle(100, "rmid_idle");

      // Randomized queues per requester against a queue-level round-robin model
      for (int r = 0; r < 4; r++) begin
         do_reset();
         total = 0;
         for (int k = 0; k < NUM_REQ; k++) begin
            rq_len[k]  = int'($urandom_range(4, 0));
            rq_head[k] = 0;
            for (int j = 0; j < 8; j++) rq_mem[k][j] = 8'($urandom);
            m_left[k] = rq_len[k];
            total += rq_len[k];
            drive_req(k);
         end
         exp_id.delete();
         exp_byte.delete();
         m_last = NUM_REQ - 1;
         for (int g = 0; g < total; g++) begin
            found = 0;
            for (int i = 1; i <= NUM_REQ; i++) begin
               c = (m_last + i) % NUM_REQ;
               if (!found && m_left[c] > 0) begin
                  found = 1;
                  exp_id.push_back(c);
                  exp_byte.push_back(rq_mem[c][rq_len[c] - m_left[c]]);
                  m_left[c]--;
                  m_last = c;
               end
            end
         end
         auto_uart = 1;
         rand_mode = 1;
         wait_starts(total * STEP, 3000, $sformatf("rand%0d_starts", r));
         wait_idle(200, $sformatf("rand%0d_idle", r));
         rand_mode = 0;
         chk($sformatf("rand%0d_count", r), 32'(obs_id.size()), 32'(total * STEP));
         for (int g = 0; g < total; g++) begin
            if (g * STEP + TAG < obs_id.size()) begin
               chk($sformatf("rand%0d_id%0d", r, g),   32'(obs_id[g*STEP]),       32'(exp_id[g]));
               chk($sformatf("rand%0d_ack%0d", r, g),  32'(obs_ack[g*STEP]),      32'd1 << exp_id[g]);
               chk($sformatf("rand%0d_data%0d", r, g), 32'(obs_data[g*STEP+TAG]), 32'(exp_byte[g]));
            end
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
